// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter
// Shares the CPU's single downstream memory bus between the data-side port
// (load/store via the write buffer) and the instruction-fetch port.
// Data has fixed priority. A streak counter bounds how many data grants in a
// row can pass over a waiting fetch. All outputs come straight from flops.

module cpu_bus_arbiter #(
    parameter int unsigned MAX_CONSECUTIVE = 4
) (
    input  logic        i_clock,
    input  logic        i_reset,
    // downstream bus
    output logic        o_bus_rw,
    output logic        o_bus_request,
    input  logic        i_bus_ready,
    output logic [31:0] o_bus_address,
    input  logic [31:0] i_bus_rdata,
    output logic [31:0] o_bus_wdata,
    // data port
    input  logic        i_d_rw,
    input  logic        i_d_request,
    input  logic [31:0] i_d_address,
    input  logic [31:0] i_d_wdata,
    output logic        o_d_ready,
    output logic [31:0] o_d_rdata,
    // fetch port
    input  logic        i_f_rw,
    input  logic        i_f_request,
    input  logic [31:0] i_f_address,
    input  logic [31:0] i_f_wdata,
    output logic        o_f_ready,
    output logic [31:0] o_f_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUS     = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    localparam logic       OWNER_DATA  = 1'b0;
    localparam logic       OWNER_FETCH = 1'b1;
    localparam logic [3:0] STREAK_SAT  = 4'd15;
    localparam logic [3:0] STREAK_LIM  = 4'(MAX_CONSECUTIVE);

    state_e      state_q,       state_d;
    logic        owner_q,       owner_d;
    logic [3:0]  streak_q,      streak_d;
    logic        bus_rw_q,      bus_rw_d;
    logic        bus_request_q, bus_request_d;
    logic [31:0] bus_address_q, bus_address_d;
    logic [31:0] bus_wdata_q,   bus_wdata_d;
    logic        d_ready_q,     d_ready_d;
    logic [31:0] d_rdata_q,     d_rdata_d;
    logic        f_ready_q,     f_ready_d;
    logic [31:0] f_rdata_q,     f_rdata_d;

    logic        grant_fetch_s;
    logic        owner_request_s;

    // Next-state logic: arbitration in IDLE, completion in BUS, handshake close in RELEASE.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        streak_d      = streak_q;
        bus_rw_d      = bus_rw_q;
        bus_request_d = bus_request_q;
        bus_address_d = bus_address_q;
        bus_wdata_d   = bus_wdata_q;
        d_ready_d     = d_ready_q;
        d_rdata_d     = d_rdata_q;
        f_ready_d     = f_ready_q;
        f_rdata_d     = f_rdata_q;
        grant_fetch_s = 1'b0;

        if (owner_q == OWNER_FETCH) begin
            owner_request_s = i_f_request;
        end else begin
            owner_request_s = i_d_request;
        end

        case (state_q)
            ST_IDLE: begin
                if (i_d_request || i_f_request) begin
                    // Fetch wins only when alone or when data has had its full streak.
                    grant_fetch_s = i_f_request && (!i_d_request || (streak_q >= STREAK_LIM));
                    owner_d       = grant_fetch_s ? OWNER_FETCH : OWNER_DATA;
                    if (grant_fetch_s) begin
                        bus_rw_d      = i_f_rw;
                        bus_address_d = i_f_address;
                        bus_wdata_d   = i_f_wdata;
                    end else begin
                        bus_rw_d      = i_d_rw;
                        bus_address_d = i_d_address;
                        bus_wdata_d   = i_d_wdata;
                    end
                    bus_request_d = 1'b1;
                    // Streak counts only data grants that pass over a waiting fetch.
                    if (!grant_fetch_s && i_f_request) begin
                        if (streak_q == STREAK_SAT) begin
                            streak_d = streak_q;
                        end else begin
                            streak_d = streak_q + 4'd1;
                        end
                    end else begin
                        streak_d = 4'd0;
                    end
                    state_d = ST_BUS;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_BUS: begin
                if (i_bus_ready) begin
                    bus_request_d = 1'b0;
                    if (owner_request_s) begin
                        // Writes leave the owner's read data untouched.
                        if (owner_q == OWNER_FETCH) begin
                            f_ready_d = 1'b1;
                            if (!bus_rw_q) begin
                                f_rdata_d = i_bus_rdata;
                            end else begin
                                f_rdata_d = f_rdata_q;
                            end
                        end else begin
                            d_ready_d = 1'b1;
                            if (!bus_rw_q) begin
                                d_rdata_d = i_bus_rdata;
                            end else begin
                                d_rdata_d = d_rdata_q;
                            end
                        end
                        state_d = ST_RELEASE;
                    end else begin
                        // Requester walked away mid-transaction: finish the bus cycle silently.
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_BUS;
                end
            end

            ST_RELEASE: begin
                if (!owner_request_s) begin
                    d_ready_d = 1'b0;
                    f_ready_d = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_RELEASE;
                end
            end

            default: begin
                bus_request_d = 1'b0;
                d_ready_d     = 1'b0;
                f_ready_d     = 1'b0;
                state_d       = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset that clears everything.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q       <= ST_IDLE;
            owner_q       <= OWNER_DATA;
            streak_q      <= 4'd0;
            bus_rw_q      <= 1'b0;
            bus_request_q <= 1'b0;
            bus_address_q <= 32'h0000_0000;
            bus_wdata_q   <= 32'h0000_0000;
            d_ready_q     <= 1'b0;
            d_rdata_q     <= 32'h0000_0000;
            f_ready_q     <= 1'b0;
            f_rdata_q     <= 32'h0000_0000;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            streak_q      <= streak_d;
            bus_rw_q      <= bus_rw_d;
            bus_request_q <= bus_request_d;
            bus_address_q <= bus_address_d;
            bus_wdata_q   <= bus_wdata_d;
            d_ready_q     <= d_ready_d;
            d_rdata_q     <= d_rdata_d;
            f_ready_q     <= f_ready_d;
            f_rdata_q     <= f_rdata_d;
        end
    end

    assign o_bus_rw      = bus_rw_q;
    assign o_bus_request = bus_request_q;
    assign o_bus_address = bus_address_q;
    assign o_bus_wdata   = bus_wdata_q;
    assign o_d_ready     = d_ready_q;
    assign o_d_rdata     = d_rdata_q;
    assign o_f_ready     = f_ready_q;
    assign o_f_rdata     = f_rdata_q;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Testbench for cpu_bus_arbiter: directed scenarios against fixed expected
// values, then a randomized run against a transaction-rule reference model.

module tb_cpu_bus_arbiter;

    localparam int MAXC = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        bus_ready;
    logic [31:0] bus_rdata;
    logic        d_rw, d_req, f_rw, f_req;
    logic [31:0] d_addr, d_wdata, f_addr, f_wdata;
    logic        o_bus_rw, o_bus_request, o_d_ready, o_f_ready;
    logic [31:0] o_bus_address, o_bus_wdata, o_d_rdata, o_f_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int          m_phase;   // 0 free, 1 waiting on bus, 2 waiting for requester to let go
    int          m_owner;
    int          m_streak;
    logic        m_bus_req, m_bus_rw;
    logic [31:0] m_bus_addr, m_bus_wdata;
    logic        m_rdy   [2];
    logic [31:0] m_rdata [2];

    cpu_bus_arbiter #(.MAX_CONSECUTIVE(MAXC)) dut (
        .i_clock(clk), .i_reset(rst),
        .o_bus_rw(o_bus_rw), .o_bus_request(o_bus_request), .i_bus_ready(bus_ready),
        .o_bus_address(o_bus_address), .i_bus_rdata(bus_rdata), .o_bus_wdata(o_bus_wdata),
        .i_d_rw(d_rw), .i_d_request(d_req), .i_d_address(d_addr), .i_d_wdata(d_wdata),
        .o_d_ready(o_d_ready), .o_d_rdata(o_d_rdata),
        .i_f_rw(f_rw), .i_f_request(f_req), .i_f_address(f_addr), .i_f_wdata(f_wdata),
        .o_f_ready(o_f_ready), .o_f_rdata(o_f_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance the model by the rules of one clock edge using the inputs now applied.
    task automatic model_step();
        logic        req [2];
        logic        rwi [2];
        logic [31:0] ai  [2];
        logic [31:0] wi  [2];
        int pick;
        req[0] = d_req; rwi[0] = d_rw; ai[0] = d_addr; wi[0] = d_wdata;
        req[1] = f_req; rwi[1] = f_rw; ai[1] = f_addr; wi[1] = f_wdata;
        if (rst) begin
            m_phase = 0; m_owner = 0; m_streak = 0;
            m_bus_req = 1'b0; m_bus_rw = 1'b0; m_bus_addr = 32'h0; m_bus_wdata = 32'h0;
            m_rdy[0] = 1'b0; m_rdy[1] = 1'b0; m_rdata[0] = 32'h0; m_rdata[1] = 32'h0;
        end else if (m_phase == 0) begin
            if (req[0] || req[1]) begin
                pick = (req[0] && !(req[1] && m_streak >= MAXC)) ? 0 : 1;
                m_owner = pick;
                m_bus_rw = rwi[pick]; m_bus_addr = ai[pick]; m_bus_wdata = wi[pick];
                m_bus_req = 1'b1;
                m_streak = (pick == 0 && req[1]) ? ((m_streak < 15) ? m_streak + 1 : 15) : 0;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (bus_ready) begin
                m_bus_req = 1'b0;
                if (req[m_owner]) begin
                    if (!m_bus_rw) m_rdata[m_owner] = bus_rdata;
                    m_rdy[m_owner] = 1'b1;
                    m_phase = 2;
                end else begin
                    m_phase = 0;
                end
            end
        end else begin
            if (!req[m_owner]) begin
                m_rdy[m_owner] = 1'b0;
                m_phase = 0;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_checks++; if (o_bus_request !== 1'b0) begin n_fail++; $display("FAIL reset_bus_request: got %0b want 0", o_bus_request); end
        n_checks++; if (o_d_ready !== 1'b0) begin n_fail++; $display("FAIL reset_d_ready: got %0b want 0", o_d_ready); end
        n_checks++; if (o_f_ready !== 1'b0) begin n_fail++; $display("FAIL reset_f_ready: got %0b want 0", o_f_ready); end
        n_checks++; if ({o_bus_rw, o_bus_address, o_bus_wdata, o_d_rdata, o_f_rdata} !== 129'd0) begin n_fail++;
            $display("FAIL reset_fields: got %h %h %h %h %h want all 0", o_bus_rw, o_bus_address, o_bus_wdata, o_d_rdata, o_f_rdata); end
        rst = 1'b0;
    endtask

    task automatic test_data_read();
        d_rw = 1'b0; d_addr = 32'h0000_1000; d_wdata = 32'h0; d_req = 1'b1;
        tick();
        n_checks++; if (o_bus_request !== 1'b1) begin n_fail++; $display("FAIL rd_grant: got %0b want 1", o_bus_request); end
        n_checks++; if (o_bus_address !== 32'h0000_1000) begin n_fail++; $display("FAIL rd_addr: got %h want 00001000", o_bus_address); end
        n_checks++; if (o_bus_rw !== 1'b0) begin n_fail++; $display("FAIL rd_rw: got %0b want 0", o_bus_rw); end
        tick(); tick();
        n_checks++; if (o_d_ready !== 1'b0 || o_bus_request !== 1'b1) begin n_fail++; $display("FAIL rd_wait: got ready=%0b req=%0b want 0/1", o_d_ready, o_bus_request); end
        bus_ready = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        tick();
        n_checks++; if (o_bus_request !== 1'b0) begin n_fail++; $display("FAIL rd_bus_drop: got %0b want 0", o_bus_request); end
        n_checks++; if (o_d_ready !== 1'b1) begin n_fail++; $display("FAIL rd_ready: got %0b want 1", o_d_ready); end
        n_checks++; if (o_d_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_rdata: got %h want deadbeef", o_d_rdata); end
        n_checks++; if (o_f_ready !== 1'b0 || o_f_rdata !== 32'h0) begin n_fail++; $display("FAIL rd_f_untouched: got %0b %h want 0 0", o_f_ready, o_f_rdata); end
        bus_ready = 1'b0; d_req = 1'b0;
        tick();
        n_checks++; if (o_d_ready !== 1'b0) begin n_fail++; $display("FAIL rd_release: got %0b want 0", o_d_ready); end
        n_checks++; if (o_d_rdata !== 32'hDEAD_BEEF || o_bus_address !== 32'h0000_1000) begin n_fail++;
            $display("FAIL rd_hold: got %h %h want deadbeef 00001000", o_d_rdata, o_bus_address); end
    endtask

    task automatic test_fetch_write();
        f_rw = 1'b1; f_addr = 32'h0000_0020; f_wdata = 32'h1234_5678; f_req = 1'b1;
        bus_ready = 1'b1; bus_rdata = 32'hCAFE_F00D;
        tick();
        n_checks++; if (o_bus_request !== 1'b1 || o_bus_rw !== 1'b1) begin n_fail++; $display("FAIL wr_grant: got req=%0b rw=%0b want 1/1", o_bus_request, o_bus_rw); end
        n_checks++; if (o_bus_wdata !== 32'h1234_5678 || o_bus_address !== 32'h0000_0020) begin n_fail++;
            $display("FAIL wr_fields: got %h %h want 12345678 00000020", o_bus_wdata, o_bus_address); end
        tick();
        n_checks++; if (o_f_ready !== 1'b1) begin n_fail++; $display("FAIL wr_ready: got %0b want 1", o_f_ready); end
        n_checks++; if (o_f_rdata !== 32'h0) begin n_fail++; $display("FAIL wr_rdata_kept: got %h want 0", o_f_rdata); end
        n_checks++; if (o_d_ready !== 1'b0 || o_d_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_d_untouched: got %0b %h", o_d_ready, o_d_rdata); end
        f_req = 1'b0; bus_ready = 1'b0;
        tick();
        n_checks++; if (o_f_ready !== 1'b0 || o_bus_rw !== 1'b1) begin n_fail++; $display("FAIL wr_release: got ready=%0b rw=%0b want 0/1", o_f_ready, o_bus_rw); end
    endtask

    task automatic test_contention();
        int   grants [10];
        int   ng;
        logic prev;
        int   want [10];
        want = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        ng = 0; prev = o_bus_request;
        d_rw = 1'b0; d_addr = 32'h0000_D000; d_wdata = 32'h0;
        f_rw = 1'b0; f_addr = 32'hF000_0000; f_wdata = 32'h0;
        bus_ready = 1'b1; bus_rdata = 32'h5555_AAAA;
        d_req = 1'b1; f_req = 1'b1;
        for (int cyc = 0; cyc < 200 && ng < 10; cyc++) begin
            tick();
            n_checks++; if (o_d_ready && o_f_ready) begin n_fail++; $display("FAIL cont_exclusive: both readies high at cycle %0d", cyc); end
            if (o_bus_request && !prev) begin
                grants[ng] = (o_bus_address == 32'hF000_0000) ? 1 : 0;
                ng++;
            end
            prev = o_bus_request;
            if (d_req && o_d_ready) d_req = 1'b0; else if (!d_req && !o_d_ready) d_req = 1'b1;
            if (f_req && o_f_ready) f_req = 1'b0; else if (!f_req && !o_f_ready) f_req = 1'b1;
        end
        n_checks++; if (ng != 10) begin n_fail++; $display("FAIL cont_count: got %0d grants want 10", ng); end
        for (int i = 0; i < ng; i++) begin
            n_checks++; if (grants[i] != want[i]) begin n_fail++; $display("FAIL cont_order[%0d]: got %0d want %0d (0=D 1=F)", i, grants[i], want[i]); end
        end
        d_req = 1'b0; f_req = 1'b0;
        tick(); tick(); tick();
        bus_ready = 1'b0;
    endtask

    task automatic test_protocol_violation();
        d_rw = 1'b0; d_addr = 32'h0000_0300; d_req = 1'b1; bus_ready = 1'b0;
        tick();
        n_checks++; if (o_bus_request !== 1'b1) begin n_fail++; $display("FAIL pv_grant: got %0b want 1", o_bus_request); end
        d_req = 1'b0;
        tick();
        n_checks++; if (o_bus_request !== 1'b1) begin n_fail++; $display("FAIL pv_wait: got %0b want 1", o_bus_request); end
        bus_ready = 1'b1; bus_rdata = 32'h1111_1111;
        tick();
        n_checks++; if (o_bus_request !== 1'b0 || o_d_ready !== 1'b0) begin n_fail++; $display("FAIL pv_no_ready: got req=%0b ready=%0b want 0/0", o_bus_request, o_d_ready); end
        n_checks++; if (o_d_rdata !== 32'h5555_AAAA) begin n_fail++; $display("FAIL pv_rdata_kept: got %h want 5555aaaa", o_d_rdata); end
        bus_ready = 1'b0;
        tick();
        n_checks++; if (o_bus_request !== 1'b0 || o_d_ready !== 1'b0) begin n_fail++; $display("FAIL pv_idle: got req=%0b ready=%0b want 0/0", o_bus_request, o_d_ready); end
        d_addr = 32'h0000_0304; d_req = 1'b1; bus_ready = 1'b1; bus_rdata = 32'h2222_2222;
        tick();
        n_checks++; if (o_bus_request !== 1'b1 || o_bus_address !== 32'h0000_0304) begin n_fail++; $display("FAIL pv_next_grant: got %0b %h", o_bus_request, o_bus_address); end
        tick();
        n_checks++; if (o_d_ready !== 1'b1 || o_d_rdata !== 32'h2222_2222) begin n_fail++; $display("FAIL pv_next_done: got %0b %h want 1 22222222", o_d_ready, o_d_rdata); end
        d_req = 1'b0; bus_ready = 1'b0;
        tick();
    endtask

    task automatic test_reset_in_bus();
        f_rw = 1'b0; f_addr = 32'h0000_0400; f_req = 1'b1;
        tick();
        n_checks++; if (o_bus_request !== 1'b1) begin n_fail++; $display("FAIL rb_grant: got %0b want 1", o_bus_request); end
        rst = 1'b1;
        tick();
        n_checks++; if ({o_bus_request, o_bus_rw, o_bus_address, o_bus_wdata, o_d_ready, o_d_rdata, o_f_ready, o_f_rdata} !== 132'd0) begin n_fail++;
            $display("FAIL rb_all_zero: got req=%0b addr=%h fready=%0b frdata=%h drdata=%h", o_bus_request, o_bus_address, o_f_ready, o_f_rdata, o_d_rdata); end
        rst = 1'b0; bus_ready = 1'b1; bus_rdata = 32'h7777_7777;
        tick();
        n_checks++; if (o_f_ready !== 1'b0 || o_bus_request !== 1'b1 || o_bus_address !== 32'h0000_0400) begin n_fail++;
            $display("FAIL rb_regrant: got ready=%0b req=%0b addr=%h want 0 1 00000400", o_f_ready, o_bus_request, o_bus_address); end
        tick();
        n_checks++; if (o_f_ready !== 1'b1 || o_f_rdata !== 32'h7777_7777) begin n_fail++; $display("FAIL rb_done: got %0b %h want 1 77777777", o_f_ready, o_f_rdata); end
        f_req = 1'b0; bus_ready = 1'b0;
        tick();
    endtask

    task automatic test_late_release();
        d_rw = 1'b1; d_addr = 32'h0000_0500; d_wdata = 32'hA5A5_A5A5; d_req = 1'b1;
        bus_ready = 1'b1; bus_rdata = 32'h0BAD_F00D;
        tick();
        n_checks++; if (o_bus_request !== 1'b1 || o_bus_wdata !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL lr_grant: got %0b %h", o_bus_request, o_bus_wdata); end
        f_rw = 1'b0; f_addr = 32'h0000_0600; f_req = 1'b1;
        tick();
        n_checks++; if (o_d_ready !== 1'b1 || o_d_rdata !== 32'h0) begin n_fail++; $display("FAIL lr_ready: got %0b %h want 1 0", o_d_ready, o_d_rdata); end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++; if (o_d_ready !== 1'b1 || o_f_ready !== 1'b0 || o_bus_request !== 1'b0) begin n_fail++;
                $display("FAIL lr_hold[%0d]: got d=%0b f=%0b req=%0b want 1 0 0", i, o_d_ready, o_f_ready, o_bus_request); end
        end
        d_req = 1'b0;
        tick();
        n_checks++; if (o_d_ready !== 1'b0 || o_bus_request !== 1'b0) begin n_fail++; $display("FAIL lr_idle_gap: got d=%0b req=%0b want 0 0", o_d_ready, o_bus_request); end
        tick();
        n_checks++; if (o_bus_request !== 1'b1 || o_bus_address !== 32'h0000_0600) begin n_fail++; $display("FAIL lr_fetch_grant: got %0b %h", o_bus_request, o_bus_address); end
        tick();
        n_checks++; if (o_f_ready !== 1'b1 || o_f_rdata !== 32'h0BAD_F00D || o_d_ready !== 1'b0) begin n_fail++;
            $display("FAIL lr_fetch_done: got f=%0b %h d=%0b", o_f_ready, o_f_rdata, o_d_ready); end
        f_req = 1'b0; bus_ready = 1'b0;
        tick();
        n_checks++; if (o_f_ready !== 1'b0) begin n_fail++; $display("FAIL lr_fetch_release: got %0b want 0", o_f_ready); end
    endtask

    task automatic test_random();
        logic [131:0] got, exp;
        rst = 1'b1; d_req = 1'b0; f_req = 1'b0; bus_ready = 1'b0;
        tick();
        rst = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            got = {o_bus_request, o_bus_rw, o_bus_address, o_bus_wdata, o_d_ready, o_d_rdata, o_f_ready, o_f_rdata};
            exp = {m_bus_req, m_bus_rw, m_bus_addr, m_bus_wdata, m_rdy[0], m_rdata[0], m_rdy[1], m_rdata[1]};
            n_checks++; if (got !== exp) begin n_fail++; $display("FAIL rand_outputs cycle %0d: got %h want %h", cyc, got, exp); end
            n_checks++; if (o_d_ready && o_f_ready) begin n_fail++; $display("FAIL rand_exclusive cycle %0d: both readies high", cyc); end
            rst = ($urandom_range(0, 399) == 0);
            bus_ready = ($urandom_range(0, 99) < 40);
            bus_rdata = $urandom;
            if (!d_req) begin
                if (!o_d_ready && $urandom_range(0, 3) == 0) begin
                    d_req = 1'b1; d_rw = $urandom_range(0, 1); d_addr = $urandom; d_wdata = $urandom;
                end
            end else if (o_d_ready) begin
                if ($urandom_range(0, 2) == 0) d_req = 1'b0;
            end else if ($urandom_range(0, 99) == 0) begin
                d_req = 1'b0;
            end
            if (!f_req) begin
                if (!o_f_ready && $urandom_range(0, 3) == 0) begin
                    f_req = 1'b1; f_rw = $urandom_range(0, 1); f_addr = $urandom; f_wdata = $urandom;
                end
            end else if (o_f_ready) begin
                if ($urandom_range(0, 2) == 0) f_req = 1'b0;
            end else if ($urandom_range(0, 99) == 0) begin
                f_req = 1'b0;
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; bus_ready = 1'b0; bus_rdata = 32'h0;
        d_rw = 1'b0; d_req = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
        f_rw = 1'b0; f_req = 1'b0; f_addr = 32'h0; f_wdata = 32'h0;
        m_phase = 0; m_owner = 0; m_streak = 0;
        m_bus_req = 1'b0; m_bus_rw = 1'b0; m_bus_addr = 32'h0; m_bus_wdata = 32'h0;
        m_rdy[0] = 1'b0; m_rdy[1] = 1'b0; m_rdata[0] = 32'h0; m_rdata[1] = 32'h0;
        @(posedge clk); #1;
        test_reset();
        test_data_read();
        test_fetch_write();
        test_contention();
        test_protocol_violation();
        test_reset_in_bus();
        test_late_release();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
